delay_tap_reader: RTL and testbench

//  Read side of the circular delay line: per committed sample, fetches NUM_TAPS delayed samples

---
 rtl/delay_pkg.sv | 40 ++++
 rtl/delay_tap_reader_if.sv | 39 +++
 rtl/delay_tap_mac.sv | 40 ++++
 rtl/delay_tap_reader.sv | 176 +++++++++++++++++
 tb/tb_delay_tap_reader.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : delay_pkg
//  Description : Shared definitions for the circular delay line: tap-reader
//                FSM states, sample range constants and the saturating
//                narrowing helper used by the reader and the writer/feedback
//                path.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } reader_state_e;

    localparam int SAMPLE_WIDTH = 32;
    localparam logic signed [SAMPLE_WIDTH-1:0] MAX_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] MAX_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // Clamp a wide signed value into the signed range of 'width' bits. The
    // result stays 64 bits wide; the caller keeps the low 'width' bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_tap_reader_if.sv
`default_nettype none
// ============================================================================
//  Interface   : delay_tap_reader_if
//  Description : Bundle between the delay-line writer / BRAM read port /
//                echo mixer and the tap reader.
//                slave  : the tap reader (consumes start, pointers, taps and
//                         rd_data; drives rd_en/rd_addr and the tap sum)
//                master : the surrounding system
//  Revision    : 1.0 - initial release
// ============================================================================
interface delay_tap_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 4,
    parameter int GAIN_WIDTH = 8
);
    logic                               start;
    logic [ADDR_WIDTH-1:0]              wr_ptr;
    logic [NUM_TAPS*ADDR_WIDTH-1:0]     tap_delay;
    logic [NUM_TAPS*GAIN_WIDTH-1:0]     tap_gain;
    logic                               rd_en;
    logic [ADDR_WIDTH-1:0]              rd_addr;
    logic signed [DATA_WIDTH-1:0]       rd_data;
    logic signed [DATA_WIDTH-1:0]       tap_out;
    logic                               tap_out_valid;
    logic                               busy;
    logic                               overrun;

    modport slave (
        input  start, wr_ptr, tap_delay, tap_gain, rd_data,
        output rd_en, rd_addr, tap_out, tap_out_valid, busy, overrun
    );

    modport master (
        output start, wr_ptr, tap_delay, tap_gain, rd_data,
        input  rd_en, rd_addr, tap_out, tap_out_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/delay_tap_mac.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_mac
//  Description : Signed sample x unsigned gain multiply-accumulate.
//                Ports: clk, reset (sync, active-high), clear (zero the
//                accumulator), en (accumulate this cycle's product),
//                data (signed sample), gain (unsigned), acc_next (running
//                sum including the current product, for same-cycle capture).
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 8,
    parameter int ACC_WIDTH  = 43
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         clear,
    input  wire logic                         en,
    input  wire logic signed [DATA_WIDTH-1:0] data,
    input  wire logic [GAIN_WIDTH-1:0]        gain,
    output logic signed [ACC_WIDTH-1:0]       acc_next
);
    localparam int C_PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;

    logic signed [C_PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    // Gain is zero-extended by one bit so it multiplies as a non-negative value.
    assign w_prod   = C_PROD_WIDTH'(data) * C_PROD_WIDTH'($signed({1'b0, gain}));
    assign acc_next = r_acc + ACC_WIDTH'(w_prod);

    always_ff @(posedge clk) begin
        if (reset || clear)
            r_acc <= '0;
        else if (en)
            r_acc <= acc_next;
    end
endmodule
`default_nettype wire

// File: rtl/delay_tap_reader.sv
`default_nettype none
// ============================================================================
//  Module      : delay_tap_reader
//  Description : Read side of the circular delay line. Per start pulse it
//                snapshots wr_ptr/tap_delay/tap_gain, issues NUM_TAPS BRAM
//                reads (one per cycle), accumulates rd_data * gain and emits
//                (sum >>> GAIN_WIDTH) narrowed to DATA_WIDTH.
//                Ports: clk, reset (sync, active-high), bus (slave modport:
//                start, wr_ptr, tap_delay, tap_gain, rd_data in; rd_en,
//                rd_addr, tap_out, tap_out_valid, busy, overrun out).
//                Build option DELAY_TAP_SAT_EN: saturate the narrowed sum
//                instead of keeping its low DATA_WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_reader
    import delay_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 4,
    parameter int GAIN_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    delay_tap_reader_if.slave bus
);
    localparam int C_IDX_WIDTH = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int C_ACC_WIDTH = DATA_WIDTH + GAIN_WIDTH + $clog2(NUM_TAPS) + 1;
    localparam logic [C_IDX_WIDTH-1:0] C_LAST_IDX = C_IDX_WIDTH'(NUM_TAPS - 1);

    reader_state_e                r_state;
    logic [ADDR_WIDTH-1:0]        r_wr_ptr_snap;
    logic [ADDR_WIDTH-1:0]        r_delay_snap [NUM_TAPS];
    logic [GAIN_WIDTH-1:0]        r_gain_snap  [NUM_TAPS];
    logic [C_IDX_WIDTH-1:0]       r_issue_idx;
    logic                         r_rd_en;
    logic [ADDR_WIDTH-1:0]        r_rd_addr;
    logic signed [DATA_WIDTH-1:0] r_tap_out;
    logic                         r_tap_out_valid;
    logic                         r_busy;
    logic                         r_overrun;

    // Read-return tracking: entry RD_LATENCY-1 lines up with rd_data.
    logic [RD_LATENCY-1:0]        r_vld;
    logic [C_IDX_WIDTH-1:0]       r_vidx  [RD_LATENCY];
    logic [GAIN_WIDTH-1:0]        r_vgain [RD_LATENCY];

    logic                          w_accept;
    logic                          w_last;
    logic [C_IDX_WIDTH-1:0]        w_next_idx;
    logic signed [C_ACC_WIDTH-1:0] w_acc_next;
    logic signed [C_ACC_WIDTH-1:0] w_scaled;
    logic signed [DATA_WIDTH-1:0]  w_narrow;

    assign w_accept   = bus.start && (r_state == ST_IDLE);
    assign w_last     = r_vld[RD_LATENCY-1] && (r_vidx[RD_LATENCY-1] == C_LAST_IDX);
    assign w_next_idx = r_issue_idx + C_IDX_WIDTH'(1);
    assign w_scaled   = w_acc_next >>> GAIN_WIDTH;

`ifdef DELAY_TAP_SAT_EN
    logic signed [63:0] w_wide;
    logic signed [63:0] w_clamped;
    logic               w_unused_hi;
    assign w_wide      = 64'(w_scaled);
    assign w_clamped   = sat_narrow(w_wide, DATA_WIDTH);
    assign w_narrow    = w_clamped[DATA_WIDTH-1:0];
    assign w_unused_hi = ^w_clamped[63:DATA_WIDTH];
`else
    logic w_unused_hi;
    assign w_narrow    = w_scaled[DATA_WIDTH-1:0];
    assign w_unused_hi = ^w_scaled[C_ACC_WIDTH-1:DATA_WIDTH];
`endif

    delay_tap_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH),
        .ACC_WIDTH  (C_ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_accept),
        .en       (r_vld[RD_LATENCY-1]),
        .data     (bus.rd_data),
        .gain     (r_vgain[RD_LATENCY-1]),
        .acc_next (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_wr_ptr_snap   <= '0;
            r_issue_idx     <= '0;
            r_rd_en         <= 1'b0;
            r_rd_addr       <= '0;
            r_tap_out       <= '0;
            r_tap_out_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_vld           <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_delay_snap[k] <= '0;
                r_gain_snap[k]  <= '0;
            end
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_vidx[i]  <= '0;
                r_vgain[i] <= '0;
            end
        end else begin
            // The registered rd_en/issue index describe the read on the bus
            // this cycle; push them down the return pipeline.
            r_vld[0]   <= r_rd_en;
            r_vidx[0]  <= r_issue_idx;
            r_vgain[0] <= r_gain_snap[r_issue_idx];
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_vidx[i]  <= r_vidx[i-1];
                r_vgain[i] <= r_vgain[i-1];
            end

            r_tap_out_valid <= 1'b0;
            if (bus.start && (r_state != ST_IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_wr_ptr_snap <= bus.wr_ptr;
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            r_delay_snap[k] <= bus.tap_delay[k*ADDR_WIDTH +: ADDR_WIDTH];
                            r_gain_snap[k]  <= bus.tap_gain[k*GAIN_WIDTH +: GAIN_WIDTH];
                        end
                        // Tap 0 goes out on the very next cycle, so it is
                        // computed from the live inputs being snapshotted.
                        r_issue_idx <= '0;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= bus.wr_ptr - bus.tap_delay[ADDR_WIDTH-1:0];
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_issue_idx == C_LAST_IDX) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_issue_idx <= w_next_idx;
                        r_rd_addr   <= r_wr_ptr_snap - r_delay_snap[w_next_idx];
                    end
                end
                ST_DRAIN: begin
                    // Capture the sum including the final product so the
                    // result appears together with the OUT state.
                    if (w_last) begin
                        r_tap_out       <= w_narrow;
                        r_tap_out_valid <= 1'b1;
                        r_state         <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_en         = r_rd_en;
    assign bus.rd_addr       = r_rd_addr;
    assign bus.tap_out       = r_tap_out;
    assign bus.tap_out_valid = r_tap_out_valid;
    assign bus.busy          = r_busy;
    assign bus.overrun       = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_delay_tap_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_tap_reader
//  Description : Self-checking bench for delay_tap_reader with a 2-cycle
//                BRAM model and a tap-sum reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_tap_reader;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int NT  = 4;
    localparam int GW  = 8;
    localparam int RL  = 2;
    localparam int LAT = NT + RL + 1;

    typedef int arr4_t [4];

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    delay_tap_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .GAIN_WIDTH(GW)) bus ();

    delay_tap_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .GAIN_WIDTH(GW), .RD_LATENCY(RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // BRAM model: data appears RL cycles after the enabled read.
    logic signed [31:0] mem [0:65535];
    logic signed [31:0] bram_p1;
    always @(posedge clk) begin
        if (bus.rd_en)
            bram_p1 <= mem[bus.rd_addr];
        bus.rd_data <= bram_p1;
    end

    int                 obs_en    [0:15];
    int                 obs_addr  [0:15];
    int                 obs_busy  [0:15];
    int                 obs_valid [0:15];
    int                 obs_ovr   [0:15];
    logic signed [31:0] obs_out   [0:15];

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 65536; a++)
            case (mode)
                0:       mem[a] = a * 16;
                1:       mem[a] = 32'sh7FFF_FFFF;
                default: mem[a] = $urandom;
            endcase
    endtask

    function automatic int tap_addr(input int wr, input int d);
        return ((wr - d) % 65536 + 65536) % 65536;
    endfunction

    function automatic logic signed [31:0] ref_out(input int wr, input arr4_t d, input arr4_t g);
        longint s;
        longint q;
        s = 0;
        for (int k = 0; k < NT; k++)
            s += longint'(mem[tap_addr(wr, d[k])]) * longint'(g[k]);
        q = s >>> GW;
`ifdef DELAY_TAP_SAT_EN
        if (q > 64'sd2147483647)       q = 64'sd2147483647;
        else if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
        return q[31:0];
    endfunction

    function automatic arr4_t rand4(input int maxv);
        arr4_t r;
        for (int k = 0; k < NT; k++) r[k] = $urandom_range(0, maxv);
        return r;
    endfunction

    // Drives one start (cycle 0 = now) and records outputs at cycles 1..n.
    task automatic run_sample(input int wr, input arr4_t d, input arr4_t g, input int n_cyc,
                              input int start2_cyc, input int change_cyc, input int reset_cyc);
        for (int c = 0; c < 16; c++) begin
            obs_en[c] = 0; obs_addr[c] = 0; obs_busy[c] = 0;
            obs_valid[c] = 0; obs_ovr[c] = 0; obs_out[c] = 0;
        end
        bus.start     = 1'b1;
        bus.wr_ptr    = 16'(wr);
        bus.tap_delay = {16'(d[3]), 16'(d[2]), 16'(d[1]), 16'(d[0])};
        bus.tap_gain  = {8'(g[3]), 8'(g[2]), 8'(g[1]), 8'(g[0])};
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            reset     = 1'b0;
            if (c == start2_cyc) bus.start = 1'b1;
            if (c == change_cyc) begin
                bus.wr_ptr    = 16'($urandom);
                bus.tap_delay = {$urandom, $urandom};
                bus.tap_gain  = $urandom;
            end
            if (c == reset_cyc) reset = 1'b1;
            obs_en[c]    = int'(bus.rd_en);
            obs_addr[c]  = int'(bus.rd_addr);
            obs_busy[c]  = int'(bus.busy);
            obs_valid[c] = int'(bus.tap_out_valid);
            obs_ovr[c]   = int'(bus.overrun);
            obs_out[c]   = bus.tap_out;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", bus.rd_en); end
        n_checks++; if (bus.rd_addr !== 16'h0) begin n_fail++; $display("FAIL reset_rd_addr got %h want 0", bus.rd_addr); end
        n_checks++; if (bus.tap_out !== 32'sh0) begin n_fail++; $display("FAIL reset_tap_out got %h want 0", bus.tap_out); end
        n_checks++; if (bus.tap_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.tap_out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        // start coincident with reset must be dropped
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_with_reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL start_with_reset_rd_en got %b want 0", bus.rd_en); end
    endtask

    task automatic test_basic();
        arr4_t d, g;
        logic signed [31:0] exp_out;
        fill_mem(0);
        d = '{0, 1, 10, 100};
        g = '{128, 0, 0, 0};
        exp_out = ref_out(100, d, g);
        run_sample(100, d, g, 12, -1, -1, -1);
        for (int c = 1; c <= 12; c++) begin
            n_checks++; if (obs_en[c] != ((c <= NT) ? 1 : 0)) begin n_fail++; $display("FAIL basic_rd_en c=%0d got %0d want %0d", c, obs_en[c], (c <= NT) ? 1 : 0); end
            if (c <= NT) begin
                n_checks++; if (obs_addr[c] != tap_addr(100, d[c-1])) begin n_fail++; $display("FAIL basic_rd_addr c=%0d got %0d want %0d", c, obs_addr[c], tap_addr(100, d[c-1])); end
            end
            n_checks++; if (obs_busy[c] != ((c <= LAT) ? 1 : 0)) begin n_fail++; $display("FAIL basic_busy c=%0d got %0d want %0d", c, obs_busy[c], (c <= LAT) ? 1 : 0); end
            n_checks++; if (obs_valid[c] != ((c == LAT) ? 1 : 0)) begin n_fail++; $display("FAIL basic_valid c=%0d got %0d want %0d", c, obs_valid[c], (c == LAT) ? 1 : 0); end
            n_checks++; if (obs_ovr[c] != 0) begin n_fail++; $display("FAIL basic_overrun c=%0d got %0d want 0", c, obs_ovr[c]); end
        end
        n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL basic_tap_out got %0d want %0d", obs_out[LAT], exp_out); end
        n_checks++; if (obs_out[LAT] !== 32'sd800) begin n_fail++; $display("FAIL basic_tap_out_800 got %0d want 800", obs_out[LAT]); end
        n_checks++; if (obs_out[12] !== 32'sd800) begin n_fail++; $display("FAIL basic_tap_out_hold got %0d want 800", obs_out[12]); end
    endtask

    task automatic test_wrap();
        arr4_t d, g;
        fill_mem(0);
        d = '{6, 0, 0, 0};
        g = '{255, 0, 0, 0};
        run_sample(5, d, g, 10, -1, -1, -1);
        n_checks++; if (obs_addr[1] != 32'hFFFF) begin n_fail++; $display("FAIL wrap_rd_addr got %h want ffff", obs_addr[1]); end
        n_checks++; if (obs_out[LAT] !== ref_out(5, d, g)) begin n_fail++; $display("FAIL wrap_tap_out got %0d want %0d", obs_out[LAT], ref_out(5, d, g)); end
        n_checks++; if (obs_out[LAT] !== 32'sd1044464) begin n_fail++; $display("FAIL wrap_tap_out_const got %0d want 1044464", obs_out[LAT]); end
    endtask

    task automatic test_saturate();
        arr4_t d, g;
        logic signed [31:0] want;
        fill_mem(1);
        d = rand4(65535);
        g = '{255, 255, 255, 255};
`ifdef DELAY_TAP_SAT_EN
        want = 32'sh7FFF_FFFF;
`else
        want = 32'shFDFF_FFFC;
`endif
        run_sample($urandom_range(0, 65535), d, g, 10, -1, -1, -1);
        n_checks++; if (obs_out[LAT] !== want) begin n_fail++; $display("FAIL saturate_tap_out got %h want %h", obs_out[LAT], want); end
        n_checks++; if (obs_valid[LAT] != 1) begin n_fail++; $display("FAIL saturate_valid got %0d want 1", obs_valid[LAT]); end
    endtask

    task automatic test_snapshot();
        arr4_t d, g;
        int wr;
        logic signed [31:0] exp_out;
        fill_mem(2);
        wr = $urandom_range(0, 65535);
        d = rand4(65535);
        g = rand4(255);
        exp_out = ref_out(wr, d, g);
        run_sample(wr, d, g, 10, -1, 2, -1);
        for (int c = 1; c <= NT; c++) begin
            n_checks++; if (obs_addr[c] != tap_addr(wr, d[c-1])) begin n_fail++; $display("FAIL snapshot_rd_addr c=%0d got %0d want %0d", c, obs_addr[c], tap_addr(wr, d[c-1])); end
        end
        n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL snapshot_tap_out got %0d want %0d", obs_out[LAT], exp_out); end
    endtask

    task automatic test_random();
        arr4_t d, g;
        int wr, nvalid;
        logic signed [31:0] exp_out;
        fill_mem(2);
        for (int it = 0; it < 12; it++) begin
            wr = $urandom_range(0, 65535);
            d = rand4(65535);
            g = rand4(255);
            exp_out = ref_out(wr, d, g);
            run_sample(wr, d, g, 10, -1, -1, -1);
            nvalid = 0;
            for (int c = 1; c <= 10; c++) nvalid += obs_valid[c];
            for (int c = 1; c <= NT; c++) begin
                n_checks++; if (obs_addr[c] != tap_addr(wr, d[c-1])) begin n_fail++; $display("FAIL random_rd_addr it=%0d c=%0d got %0d want %0d", it, c, obs_addr[c], tap_addr(wr, d[c-1])); end
            end
            n_checks++; if (nvalid != 1 || obs_valid[LAT] != 1) begin n_fail++; $display("FAIL random_valid it=%0d got count %0d at7 %0d want 1/1", it, nvalid, obs_valid[LAT]); end
            n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL random_tap_out it=%0d got %0d want %0d", it, obs_out[LAT], exp_out); end
        end
    endtask

    task automatic test_back_to_back();
        arr4_t d, g;
        int wr;
        logic signed [31:0] exp_out;
        for (int it = 0; it < 4; it++) begin
            wr = $urandom_range(0, 65535);
            d = rand4(65535);
            g = rand4(64);
            exp_out = ref_out(wr, d, g);
            run_sample(wr, d, g, LAT + 1, -1, -1, -1);
            n_checks++; if (obs_valid[LAT] != 1) begin n_fail++; $display("FAIL b2b_valid it=%0d got %0d want 1", it, obs_valid[LAT]); end
            n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL b2b_tap_out it=%0d got %0d want %0d", it, obs_out[LAT], exp_out); end
            n_checks++; if (obs_busy[LAT+1] != 0 || obs_ovr[LAT+1] != 0) begin n_fail++; $display("FAIL b2b_idle it=%0d got busy %0d overrun %0d want 0/0", it, obs_busy[LAT+1], obs_ovr[LAT+1]); end
        end
    endtask

    task automatic test_overrun();
        arr4_t d, g;
        int wr, nvalid;
        logic signed [31:0] exp_out;
        fill_mem(2);
        // start coincident with OUT
        wr = $urandom_range(0, 65535);
        d = rand4(65535);
        g = rand4(255);
        exp_out = ref_out(wr, d, g);
        run_sample(wr, d, g, 10, LAT, -1, -1);
        n_checks++; if (obs_ovr[LAT] != 0 || obs_ovr[LAT+1] != 1) begin n_fail++; $display("FAIL ovr_out_overrun got %0d/%0d want 0/1", obs_ovr[LAT], obs_ovr[LAT+1]); end
        n_checks++; if (obs_busy[LAT+1] != 0 || obs_en[LAT+1] != 0) begin n_fail++; $display("FAIL ovr_out_ignored got busy %0d rd_en %0d want 0/0", obs_busy[LAT+1], obs_en[LAT+1]); end
        n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL ovr_out_tap_out got %0d want %0d", obs_out[LAT], exp_out); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_reset_clear got %b want 0", bus.overrun); end
        // start during ISSUE, with inputs changed at the same time
        wr = $urandom_range(0, 65535);
        d = rand4(65535);
        g = rand4(255);
        exp_out = ref_out(wr, d, g);
        run_sample(wr, d, g, 12, 3, 3, -1);
        nvalid = 0;
        for (int c = 1; c <= 12; c++) nvalid += obs_valid[c];
        n_checks++; if (obs_ovr[3] != 0 || obs_ovr[4] != 1 || obs_ovr[12] != 1) begin n_fail++; $display("FAIL ovr_sticky got %0d/%0d/%0d want 0/1/1", obs_ovr[3], obs_ovr[4], obs_ovr[12]); end
        n_checks++; if (nvalid != 1 || obs_valid[LAT] != 1) begin n_fail++; $display("FAIL ovr_valid got count %0d at7 %0d want 1/1", nvalid, obs_valid[LAT]); end
        n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL ovr_tap_out got %0d want %0d", obs_out[LAT], exp_out); end
        n_checks++; if (obs_addr[4] != tap_addr(wr, d[3])) begin n_fail++; $display("FAIL ovr_rd_addr got %0d want %0d", obs_addr[4], tap_addr(wr, d[3])); end
    endtask

    task automatic test_reset_mid();
        arr4_t d, g;
        int wr, nvalid;
        logic signed [31:0] exp_out;
        fill_mem(2);
        wr = $urandom_range(0, 65535);
        d = rand4(65535);
        g = rand4(255);
        run_sample(wr, d, g, 12, -1, -1, 4);
        nvalid = 0;
        for (int c = 5; c <= 12; c++) nvalid += obs_valid[c];
        n_checks++; if (nvalid != 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", nvalid); end
        n_checks++; if (obs_en[5] != 0 || obs_busy[5] != 0 || obs_ovr[5] != 0 || obs_addr[5] != 0) begin n_fail++; $display("FAIL rstmid_outputs got en %0d busy %0d ovr %0d addr %0d want 0", obs_en[5], obs_busy[5], obs_ovr[5], obs_addr[5]); end
        n_checks++; if (obs_out[5] !== 32'sh0) begin n_fail++; $display("FAIL rstmid_tap_out got %0d want 0", obs_out[5]); end
        wr = $urandom_range(0, 65535);
        d = rand4(65535);
        g = rand4(255);
        exp_out = ref_out(wr, d, g);
        run_sample(wr, d, g, 10, -1, -1, -1);
        n_checks++; if (obs_valid[LAT] != 1) begin n_fail++; $display("FAIL rstmid_fresh_valid got %0d want 1", obs_valid[LAT]); end
        n_checks++; if (obs_out[LAT] !== exp_out) begin n_fail++; $display("FAIL rstmid_fresh_tap_out got %0d want %0d", obs_out[LAT], exp_out); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.wr_ptr    = '0;
        bus.tap_delay = '0;
        bus.tap_gain  = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_saturate();
        test_snapshot();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
